// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-RAM write and status-byte signals of the boot loader.
// slave is the loader side; master is the host/bench side.
interface imem_loader_if #(
   parameter int ADDR_W = 12
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              cpu_rst_hold;
   logic              done;
   logic              error;

   modport slave (
      input  rx_data, rx_valid, tx_ready,
      output imem_we, imem_addr, imem_wdata, tx_data, tx_valid,
             cpu_rst_hold, done, error
   );

   modport master (
      output rx_data, rx_valid, tx_ready,
      input  imem_we, imem_addr, imem_wdata, tx_data, tx_valid,
             cpu_rst_hold, done, error
   );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: framed UART byte stream -> big-endian words in instruction RAM, ACK/NAK reply.
// Define LOADER_CHECKSUM_EN to require a trailing two's-complement checksum byte per frame.
module imem_loader #(
   parameter int          ADDR_W         = 12,
   parameter int          TIMEOUT_CYCLES = 50000000,
   parameter logic [7:0]  START_BYTE     = 8'h6C
) (
   input logic         clk,
   input logic         rst,
   imem_loader_if.slave bus
);
   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;
   localparam int         TW  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
`ifdef LOADER_CHECKSUM_EN
      CSUM,
`endif
      RESP
   } state_t;

   state_t            state;
   logic [1:0]        byte_idx;
   logic [15:0]       count;
   logic [15:0]       word_idx;
   logic [7:0]        base_hi;
   logic [ADDR_W-1:0] base;
   logic [23:0]       word;
   logic [TW-1:0]     idle_cnt;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         byte_idx         <= '0;
         count            <= '0;
         word_idx         <= '0;
         base_hi          <= '0;
         base             <= '0;
         word             <= '0;
         idle_cnt         <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum             <= '0;
`endif
         bus.imem_we      <= 1'b0;
         bus.imem_addr    <= '0;
         bus.imem_wdata   <= '0;
         bus.tx_data      <= '0;
         bus.tx_valid     <= 1'b0;
         bus.cpu_rst_hold <= 1'b1;
         bus.done         <= 1'b0;
         bus.error        <= 1'b0;
      end else begin
         bus.imem_we <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.rx_valid && bus.rx_data == START_BYTE) begin
                  state            <= HDR;
                  bus.cpu_rst_hold <= 1'b1;
                  bus.done         <= 1'b0;
                  bus.error        <= 1'b0;
                  byte_idx         <= '0;
                  word_idx         <= '0;
                  idle_cnt         <= '0;
`ifdef LOADER_CHECKSUM_EN
                  csum             <= '0;
`endif
               end
            end

            RESP: begin
               // Incoming bytes are dropped until the status byte is taken.
               if (bus.tx_ready) begin
                  bus.tx_valid <= 1'b0;
                  state        <= IDLE;
                  if (bus.tx_data == ACK) begin
                     bus.done         <= 1'b1;
                     bus.cpu_rst_hold <= 1'b0;
                  end else begin
                     bus.error <= 1'b1;
                  end
               end
            end

            default: begin
               if (bus.rx_valid) begin
                  idle_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                  csum     <= csum + bus.rx_data;
`endif
                  case (state)
                     HDR: begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                           2'd0:    count[15:8] <= bus.rx_data;
                           2'd1:    count[7:0]  <= bus.rx_data;
                           2'd2:    base_hi     <= bus.rx_data;
                           default: begin
                              base <= ADDR_W'({base_hi, bus.rx_data});
                              if (count == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                                 state <= CSUM;
`else
                                 state        <= RESP;
                                 bus.tx_valid <= 1'b1;
                                 bus.tx_data  <= ACK;
`endif
                              end else begin
                                 state <= DATA;
                              end
                           end
                        endcase
                     end

                     DATA: begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                           // Address arithmetic is ADDR_W wide so it wraps on its own.
                           bus.imem_we    <= 1'b1;
                           bus.imem_addr  <= base + ADDR_W'(word_idx);
                           bus.imem_wdata <= {word, bus.rx_data};
                           word_idx       <= word_idx + 16'd1;
                           if (word_idx + 16'd1 == count) begin
`ifdef LOADER_CHECKSUM_EN
                              state <= CSUM;
`else
                              state        <= RESP;
                              bus.tx_valid <= 1'b1;
                              bus.tx_data  <= ACK;
`endif
                           end
                        end else begin
                           word <= {word[15:0], bus.rx_data};
                        end
                     end

`ifdef LOADER_CHECKSUM_EN
                     CSUM: begin
                        state        <= RESP;
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= (csum + bus.rx_data == 8'h00) ? ACK : NAK;
                     end
`endif

                     default: ;
                  endcase
               end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  // A partially assembled word is discarded here.
                  idle_cnt     <= '0;
                  state        <= RESP;
                  bus.tx_valid <= 1'b1;
                  bus.tx_data  <= NAK;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected RAM writes and status bytes are queued by the
// stimulus and popped by an independent monitor; LOADER_CHECKSUM_EN selects the framed variant.
module tb_imem_loader;
   localparam int ADDR_W = 12;
   localparam int TO     = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(
      .ADDR_W(ADDR_W),
      .TIMEOUT_CYCLES(TO),
      .START_BYTE(8'h6C)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks  = 0;
   int errors  = 0;
   int tx_seen = 0;
   int cyc     = 0;
   int last_rx = -10;

   logic [ADDR_W+31:0] wq[$];
   logic [7:0]         tq[$];
   logic [ADDR_W+31:0] exp_w;
   logic [7:0]         exp_t;
   logic [31:0]        words[4];

   // Monitor: compares every RAM write and every accepted status byte against the queues.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (!rst) begin
         if (bus.imem_we) begin
            checks = checks + 1;
            if (wq.size() == 0) begin
               errors = errors + 1;
               $display("FAIL unexpected_write actual addr=%0h data=%0h required no write", bus.imem_addr, bus.imem_wdata);
            end else begin
               exp_w = wq.pop_front();
               if ({bus.imem_addr, bus.imem_wdata} !== exp_w) begin
                  errors = errors + 1;
                  $display("FAIL write actual addr=%0h data=%0h required addr=%0h data=%0h",
                           bus.imem_addr, bus.imem_wdata, exp_w[ADDR_W+31:32], exp_w[31:0]);
               end
            end
            checks = checks + 1;
            if (last_rx != cyc - 1) begin
               errors = errors + 1;
               $display("FAIL wr_latency actual=%0d required=1", cyc - last_rx);
            end
         end
         if (bus.tx_valid && bus.tx_ready) begin
            tx_seen = tx_seen + 1;
            checks  = checks + 1;
            if (tq.size() == 0) begin
               errors = errors + 1;
               $display("FAIL unexpected_tx actual=%0h required none", bus.tx_data);
            end else begin
               exp_t = tq.pop_front();
               if (bus.tx_data !== exp_t) begin
                  errors = errors + 1;
                  $display("FAIL tx_byte actual=%0h required=%0h", bus.tx_data, exp_t);
               end
            end
         end
         if (bus.rx_valid) last_rx = cyc;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks = checks + 1;
      if (act !== req) begin
         errors = errors + 1;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] cnt, input logic [15:0] base, input int nwords,
                             input bit bad_csum);
      logic [7:0] sum;
      logic [7:0] b;
      sum = 8'h00;
      send_byte(8'h6C);
      send_byte(cnt[15:8]);  sum = sum + cnt[15:8];
      send_byte(cnt[7:0]);   sum = sum + cnt[7:0];
      send_byte(base[15:8]); sum = sum + base[15:8];
      send_byte(base[7:0]);  sum = sum + base[7:0];
      for (int i = 0; i < nwords; i++) begin
         for (int k = 3; k >= 0; k--) begin
            b   = words[i][8*k +: 8];
            sum = sum + b;
            send_byte(b);
         end
      end
`ifdef LOADER_CHECKSUM_EN
      b = 8'h00 - sum;
      if (bad_csum) b = b + 8'h01;
      send_byte(b);
`else
      if (bad_csum) b = 8'h00;
`endif
   endtask

   task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      wq.push_back({a, d});
   endtask

   task automatic wait_tx(input string name, input int max_cycles);
      int start;
      int n;
      start = tx_seen;
      n     = 0;
      while (tx_seen == start && n < max_cycles) begin
         @(posedge clk); #1;
         n = n + 1;
      end
      check({name, "_handshake"}, 64'(tx_seen != start), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_imem_we"},      64'(bus.imem_we),      64'd0);
      check({tag, "_imem_addr"},    64'(bus.imem_addr),    64'd0);
      check({tag, "_imem_wdata"},   64'(bus.imem_wdata),   64'd0);
      check({tag, "_tx_valid"},     64'(bus.tx_valid),     64'd0);
      check({tag, "_tx_data"},      64'(bus.tx_data),      64'd0);
      check({tag, "_cpu_rst_hold"}, 64'(bus.cpu_rst_hold), 64'd1);
      check({tag, "_done"},         64'(bus.done),         64'd0);
      check({tag, "_error"},        64'(bus.error),        64'd0);
   endtask

   initial begin
      int n;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      bus.tx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      // Non-start bytes in IDLE are ignored.
      send_byte(8'h00);
      send_byte(8'h72);
      repeat (3) @(posedge clk);
      #1;
      check("idle_tx_valid", 64'(bus.tx_valid), 64'd0);
      check("idle_done",     64'(bus.done),     64'd0);
      check("idle_hold",     64'(bus.cpu_rst_hold), 64'd1);

      // Two-word frame at base 0x010.
      words[0] = 32'h3C081F00;
      words[1] = 32'h350800B0;
      expect_wr(12'h010, 32'h3C081F00);
      expect_wr(12'h011, 32'h350800B0);
      tq.push_back(8'h06);
      send_frame(16'd2, 16'h0010, 2, 1'b0);
      wait_tx("frame1", 50);
      check("frame1_done",  64'(bus.done),         64'd1);
      check("frame1_hold",  64'(bus.cpu_rst_hold), 64'd0);
      check("frame1_error", 64'(bus.error),        64'd0);

      // Base 0xFFFF truncates to 0xFFF; second word wraps to 0x000.
      words[0] = 32'hDEADBEEF;
      words[1] = 32'h01234567;
      expect_wr(12'hFFF, 32'hDEADBEEF);
      expect_wr(12'h000, 32'h01234567);
      tq.push_back(8'h06);
      send_frame(16'd2, 16'hFFFF, 2, 1'b0);
      wait_tx("wrap", 50);
      check("wrap_done", 64'(bus.done), 64'd1);

      // Frame stalls after two data bytes: NAK after TO idle cycles, no partial write.
      tq.push_back(8'h15);
      send_byte(8'h6C);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h20);
      send_byte(8'hAA);
      send_byte(8'hBB);
      n = 0;
      while (!bus.tx_valid && n < 3 * TO) begin
         @(posedge clk); #1;
         n = n + 1;
      end
      check("timeout_window", 64'(n >= TO - 2 && n <= TO + 2), 64'd1);
      wait_tx("timeout", 10);
      check("timeout_error", 64'(bus.error),        64'd1);
      check("timeout_hold",  64'(bus.cpu_rst_hold), 64'd1);
      check("timeout_done",  64'(bus.done),         64'd0);

      // COUNT == 0 completes with ACK and no writes.
      tq.push_back(8'h06);
      send_frame(16'd0, 16'h0005, 0, 1'b0);
      wait_tx("count0", 50);
      check("count0_done",  64'(bus.done),  64'd1);
      check("count0_error", 64'(bus.error), 64'd0);

`ifdef LOADER_CHECKSUM_EN
      // Wrong checksum: word is still written, frame NAKed.
      words[0] = 32'h11223344;
      expect_wr(12'h040, 32'h11223344);
      tq.push_back(8'h15);
      send_frame(16'd1, 16'h0040, 1, 1'b1);
      wait_tx("badcsum", 50);
      check("badcsum_error", 64'(bus.error),        64'd1);
      check("badcsum_done",  64'(bus.done),         64'd0);
      check("badcsum_hold",  64'(bus.cpu_rst_hold), 64'd1);
`endif

      // Status held while transmitter stalls; data word made of start markers.
      bus.tx_ready = 1'b0;
      words[0] = 32'h6C6C6C6C;
      expect_wr(12'h123, 32'h6C6C6C6C);
      tq.push_back(8'h06);
      send_frame(16'd1, 16'h0123, 1, 1'b0);
      n = 0;
      while (!bus.tx_valid && n < 50) begin
         @(posedge clk); #1;
         n = n + 1;
      end
      check("stall_tx_seen", 64'(bus.tx_valid), 64'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("stall_tx_valid", 64'(bus.tx_valid), 64'd1);
         check("stall_tx_data",  64'(bus.tx_data),  64'h06);
      end
      @(posedge clk); #1;
      bus.tx_ready = 1'b1;
      wait_tx("stall", 10);
      check("stall_done", 64'(bus.done),         64'd1);
      check("stall_hold", 64'(bus.cpu_rst_hold), 64'd0);

      // Reset in the middle of DATA.
      send_byte(8'h6C);
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'hAA);
      send_byte(8'hBB);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("midrst");
      rst = 1'b0;
      send_byte(8'h3C);
      send_byte(8'h08);
      repeat (5) @(posedge clk);
      #1;
      check("midrst_after_tx_valid", 64'(bus.tx_valid), 64'd0);
      check("midrst_after_hold",     64'(bus.cpu_rst_hold), 64'd1);

      check("writes_left", 64'(wq.size()), 64'd0);
      check("tx_left",     64'(tq.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
